sd_rx_fifo: RTL and testbench
=============================

SD_RX_FIFO -- requirements
Module: sd_rx_fifo

Interface
REQ-001 Single clock; reset is asynchronous and active-low.
REQ-002 wclk  input  1  sole clock; all state updates on rising edge; there is no separate read clock.
REQ-003 rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 d  input  4  SD data-bus nibble to store.
REQ-005 wr  input  1  write strobe; d is accepted on a wclk edge where wr=1 and full=0.
REQ-006 rd  input  1  read strobe; pops the head word on a wclk edge where rd=1 and empty=0.
REQ-007 q  output  32  head-of-FIFO word, first-word-fall-through.
REQ-008 full  output  1  1 when 4 words are stored.
REQ-009 empty  output  1  1 when 0 words are stored.
REQ-010 mem_empt  output  2  saturating fill level: min(word count, 3).

Function
REQ-011 Storage SHALL be 4 words x 32 bits, with a write pointer and a read pointer each 3 bits wide (2 address bits plus 1 wrap bit).
REQ-012 A 3-bit nibble counter SHALL count accepted nibbles 0..7 and SHALL wrap from 7 to 0.
REQ-013 Nibble k of a word (k = 0..7, counting from 0) SHALL be placed at q bits [31-4k : 28-4k]; the first nibble lands in bits [31:28].
REQ-014 On the 8th accepted nibble, the completed word SHALL be written to mem[wptr] and wptr SHALL increment on that edge; the word is visible at q on the next edge if the FIFO was empty.
REQ-015 While full=1, wr SHALL be ignored entirely: no nibble is stored and the counter holds; a partial word is preserved.
REQ-016 q SHALL equal mem[rptr[1:0]] combinationally from registered state; its value is don't-care-stable (last contents) while empty.
REQ-017 A read (rd=1, empty=0) SHALL increment rptr; rd while empty SHALL be ignored.
REQ-018 Completing a word and reading on the same edge SHALL both take effect; the count is unchanged.
REQ-019 full and empty SHALL be based on the pre-edge state; a write is not allowed to bypass full even with a simultaneous read.
REQ-020 full = (wptr[1:0]==rptr[1:0]) and wrap bits differ; empty = (wptr==rptr).
REQ-021 mem_empt SHALL be 00/01/10/11 for counts 0/1/2/>=3, where count = wptr - rptr (3-bit).
REQ-022 Pointer wrap-around from address 3 to 0 SHALL toggle the wrap bit; the FIFO order is preserved across the wrap.
REQ-023 All outputs SHALL be derived from registers only, with no combinational path from d, wr, or rd to any output.

Reset
REQ-024 While rst=0: wptr=0, rptr=0, nibble counter=0, the assembly register=0, and all memory words=0.
REQ-025 Reset output values: q=0, full=0, empty=1, mem_empt=00.
REQ-026 Reset asserted mid-word or mid-read SHALL discard all data immediately (asynchronously); operation resumes at the first wclk edge after rst returns to 1.

Structure
REQ-027 A shared package sd_rx_fifo_pkg SHALL hold DEPTH=4, ADDR_W=2, WORD_W=32, NIB_W=4, and NIBBLES_PER_WORD=8.
REQ-028 One sub-module, sd_rx_nibble_packer, SHALL contain the nibble counter and the assembly register and SHALL output word + word_valid; the top level holds the memory, pointers, and flags.
REQ-029 The implementation target is 120-400 lines of RTL; no vendor RAM primitives are used.

Verification
REQ-030 Reset then idle -> q=0, empty=1, full=0, mem_empt=00 throughout.
REQ-031 Write nibbles 1,2,3,4,5,6,7,8 with wr=1 on 8 consecutive edges -> one edge later q=32'h12345678, empty=0, mem_empt=01; then rd for 1 edge -> empty=1, mem_empt=00.
REQ-032 Write 4 words (A0000000, B1111111, C2222222, D3333333) -> full=1, mem_empt=11; a further 8 nibbles of F are dropped; reading 4 times returns A,B,C,D in order, then empty=1.
REQ-033 Fill 3 words, then complete a 4th word on the same edge as rd=1 -> count stays 3, mem_empt=11, full=0; repeat 6 times so the pointers wrap -> data order stays intact.
REQ-034 Write 5 nibbles, pulse rst=0 between edges -> all outputs return to reset values immediately; a subsequent 8-nibble 9ABCDEF0 -> q=32'h9ABCDEF0.
REQ-035 rd=1 while empty for 10 edges, then write 1 word -> rptr is not corrupted: the word is read correctly and empty returns to 1.

Source files
------------

// File: rtl/sd_rx_fifo_pkg.sv
// rtl/sd_rx_fifo_pkg.sv - shared sizes, types and fill-level helper for the SD receive FIFO
package sd_rx_fifo_pkg;

    localparam int DEPTH            = 4;
    localparam int ADDR_W           = 2;
    localparam int PTR_W            = ADDR_W + 1;
    localparam int WORD_W           = 32;
    localparam int NIB_W            = 4;
    localparam int NIBBLES_PER_WORD = 8;
    localparam int CNT_W            = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  nib_cnt_t;

    // Saturating fill level: exact for 0..2 words, pinned at 3 for 3 or 4 words.
    function automatic logic [ADDR_W-1:0] fill_level(input ptr_t count);
        if (count >= ptr_t'(DEPTH - 1)) begin
            return ADDR_W'(DEPTH - 1);
        end
        return count[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sd_rx_nibble_packer.sv
// rtl/sd_rx_nibble_packer.sv - assembles eight SD bus nibbles into a 32-bit word, MSB nibble first
module sd_rx_nibble_packer
    import sd_rx_fifo_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    input  logic [NIB_W-1:0]  nib_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    word_t    asm_q, asm_d;
    nib_cnt_t cnt_q, cnt_d;

    // Drop the accepted nibble into its slot; the counter wraps 7 -> 0 on its own width.
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (accept_i) begin
            for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
                if (cnt_q == nib_cnt_t'(i)) begin
                    asm_d[(NIBBLES_PER_WORD-1-i)*NIB_W +: NIB_W] = nib_i;
                end
            end
            cnt_d = cnt_q + nib_cnt_t'(1);
        end
    end

    // The completed word includes the nibble arriving on this edge, so the FIFO
    // can store it on the same edge that accepts the eighth nibble.
    always_comb begin
        word_o       = asm_d;
        word_valid_o = accept_i && (cnt_q == nib_cnt_t'(NIBBLES_PER_WORD - 1));
    end

    // Assembly register and nibble counter; reset discards any partial word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_rx_fifo.sv
// rtl/sd_rx_fifo.sv - 4 x 32-bit first-word-fall-through FIFO fed from a 4-bit SD data bus
module sd_rx_fifo
    import sd_rx_fifo_pkg::*;
(
    input  logic        wclk,
    input  logic        rst,
    input  logic [3:0]  d,
    input  logic        wr,
    input  logic        rd,
    output logic [31:0] q,
    output logic        full,
    output logic        empty,
    output logic [1:0]  mem_empt
);

    ptr_t  wptr_q, wptr_d;
    ptr_t  rptr_q, rptr_d;
    word_t mem_q [DEPTH];

    logic  accept;
    logic  do_read;
    word_t packed_word;
    logic  packed_valid;
    ptr_t  count;

    sd_rx_nibble_packer u_packer (
        .clk_i        (wclk),
        .rst_ni       (rst),
        .accept_i     (accept),
        .nib_i        (d),
        .word_o       (packed_word),
        .word_valid_o (packed_valid)
    );

    // Flags come from registered pointers only; a full FIFO refuses nibbles even if
    // a read happens on the same edge, so the packer is simply not advanced.
    always_comb begin
        full     = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) && (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
        empty    = (wptr_q == rptr_q);
        count    = wptr_q - rptr_q;
        mem_empt = fill_level(count);
        q        = mem_q[rptr_q[ADDR_W-1:0]];
        accept   = wr && !full;
        do_read  = rd && !empty;
    end

    // Pointer advance; the wrap bit toggles naturally when the address rolls 3 -> 0.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (packed_valid) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (do_read) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Word storage; cleared on reset so q reads zero until the first word lands.
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (packed_valid) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= packed_word;
        end
    end

endmodule

// File: tb/tb_sd_rx_fifo.sv
// tb/tb_sd_rx_fifo.sv - directed self-checking bench for sd_rx_fifo
module tb_sd_rx_fifo;

    logic        wclk;
    logic        rst;
    logic [3:0]  d;
    logic        wr;
    logic        rd;
    logic [31:0] q;
    logic        full;
    logic        empty;
    logic [1:0]  mem_empt;

    int vectors;
    int miscompares;

    sd_rx_fifo dut (
        .wclk     (wclk),
        .rst      (rst),
        .d        (d),
        .wr       (wr),
        .rd       (rd),
        .q        (q),
        .full     (full),
        .empty    (empty),
        .mem_empt (mem_empt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e_empty, input logic e_full, input logic [1:0] e_lvl);
        chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
        chk({tag, ".full"}, 32'(full), 32'(e_full));
        chk({tag, ".mem_empt"}, 32'(mem_empt), 32'(e_lvl));
    endtask

    task automatic step(input logic [3:0] nib, input logic w, input logic r);
        d  = nib;
        wr = w;
        rd = r;
        @(posedge wclk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] word);
        for (int k = 0; k < 8; k++) begin
            step(word[31-4*k -: 4], 1'b1, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        d   = 4'h0;
        wr  = 1'b0;
        rd  = 1'b0;

        // reset state, then idle
        #2;
        chk("rst.q", q, 32'h0);
        chk_flags("rst", 1'b1, 1'b0, 2'd0);
        @(negedge wclk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 1'b0, 1'b0);
            chk("idle.q", q, 32'h0);
            chk_flags("idle", 1'b1, 1'b0, 2'd0);
        end

        // single word 12345678, MSB nibble first
        for (int k = 1; k <= 7; k++) step(4'(k), 1'b1, 1'b0);
        chk_flags("partial", 1'b1, 1'b0, 2'd0);
        step(4'h8, 1'b1, 1'b0);
        chk("one.q", q, 32'h12345678);
        chk_flags("one", 1'b0, 1'b0, 2'd1);
        step(4'h0, 1'b0, 1'b0);
        chk("one.hold", q, 32'h12345678);
        step(4'h0, 1'b0, 1'b1);
        chk_flags("one.read", 1'b1, 1'b0, 2'd0);

        // fill to full, overflow nibbles dropped
        push_word(32'hA0000000);
        push_word(32'hB1111111);
        push_word(32'hC2222222);
        chk_flags("three", 1'b0, 1'b0, 2'd3);
        push_word(32'hD3333333);
        chk_flags("four", 1'b0, 1'b1, 2'd3);
        push_word(32'hFFFFFFFF);
        chk_flags("ovf", 1'b0, 1'b1, 2'd3);
        chk("ovf.q", q, 32'hA0000000);
        chk("rd0", q, 32'hA0000000); step(4'h0, 1'b0, 1'b1);
        chk_flags("rd0.after", 1'b0, 1'b0, 2'd3);
        chk("rd1", q, 32'hB1111111); step(4'h0, 1'b0, 1'b1);
        chk_flags("rd1.after", 1'b0, 1'b0, 2'd2);
        chk("rd2", q, 32'hC2222222); step(4'h0, 1'b0, 1'b1);
        chk("rd3", q, 32'hD3333333); step(4'h0, 1'b0, 1'b1);
        chk_flags("drained", 1'b1, 1'b0, 2'd0);
        // the dropped F nibbles must not have advanced the packer
        push_word(32'h13579BDF);
        chk("post_ovf.q", q, 32'h13579BDF);
        chk_flags("post_ovf", 1'b0, 1'b0, 2'd1);
        step(4'h0, 1'b0, 1'b1);
        chk_flags("post_ovf.read", 1'b1, 1'b0, 2'd0);

        // sustained occupancy of 3 with simultaneous complete + read, across pointer wrap
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] nw;
            nw = 32'h11111111 * 32'(4 + i);
            for (int k = 0; k < 7; k++) step(nw[31-4*k -: 4], 1'b1, 1'b0);
            chk("stream.head", q, 32'h11111111 * 32'(1 + i));
            step(nw[3:0], 1'b1, 1'b1);
            chk_flags("stream", 1'b0, 1'b0, 2'd3);
        end
        chk("tail0", q, 32'h77777777); step(4'h0, 1'b0, 1'b1);
        chk("tail1", q, 32'h88888888); step(4'h0, 1'b0, 1'b1);
        chk("tail2", q, 32'h99999999); step(4'h0, 1'b0, 1'b1);
        chk_flags("tail.empty", 1'b1, 1'b0, 2'd0);

        // asynchronous reset mid-word with a word already stored
        push_word(32'h5A5A5A5A);
        for (int k = 0; k < 5; k++) step(4'h7, 1'b1, 1'b0);
        chk("pre_rst.q", q, 32'h5A5A5A5A);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.q", q, 32'h0);
        chk_flags("async_rst", 1'b1, 1'b0, 2'd0);
        @(negedge wclk);
        rst = 1'b1;
        push_word(32'h9ABCDEF0);
        chk("post_rst.q", q, 32'h9ABCDEF0);
        chk_flags("post_rst", 1'b0, 1'b0, 2'd1);
        step(4'h0, 1'b0, 1'b1);
        chk_flags("post_rst.read", 1'b1, 1'b0, 2'd0);

        // reads while empty must not move the read pointer
        for (int i = 0; i < 10; i++) step(4'h0, 1'b0, 1'b1);
        chk_flags("rd_empty", 1'b1, 1'b0, 2'd0);
        push_word(32'hCAFEF00D);
        chk("rd_empty.q", q, 32'hCAFEF00D);
        chk_flags("rd_empty.word", 1'b0, 1'b0, 2'd1);
        step(4'h0, 1'b0, 1'b1);
        chk_flags("rd_empty.final", 1'b1, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
